lsu_bus_ctrl: RTL and testbench
===============================

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255: bus cycles (REQ+WAIT) before timeout error; 0 disables timeout.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  execute stage presents a load/store.
REQ-005 req_ready_o  output  1  block can accept a request (high only in IDLE).
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr_i / req_wdata_i  input  32 / 32  byte address / store data (low bits significant).
REQ-009 req_rd_i  input  5  destination register, returned with response.
REQ-010 bus_req_o  output  1; bus_gnt_i  input  1  address-phase handshake.
REQ-011 bus_addr_o  output  32  word-aligned address ([1:0]=00); bus_we_o  output  1; bus_be_o  output  4; bus_wdata_o  output  32.
REQ-012 bus_rvalid_i  input  1; bus_rdata_i  input  32  response phase (ack for stores, data for loads).
REQ-013 rsp_valid_o  output  1; rsp_rd_o  output  5; rsp_rdata_o  output  32; rsp_err_o  output  1  to writeback.
REQ-014 busy_o  output  1  high in any state other than IDLE (stall to upstream).

Function
REQ-015 FSM states IDLE, REQ, WAIT, RESP; request accepted on req_valid_i & req_ready_o, all request fields registered.
REQ-016 IDLE->REQ on accept of a legal access; IDLE->RESP on accept of an illegal access (no bus activity).
REQ-017 Illegal: funct3 in {011,110,111}, or store with funct3[2]=1; response err=1, rdata=0.
REQ-018 REQ: bus_req_o=1 with addr/we/be/wdata held stable until bus_gnt_i; on gnt -> WAIT.
REQ-019 WAIT: on bus_rvalid_i -> RESP; bus_rvalid_i in any other state is ignored.
REQ-020 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; new request acceptable the following cycle.
REQ-021 Latency with gnt on first REQ cycle and rvalid the next: accept cycle N, bus_req_o N+1, rsp_valid_o N+3.
REQ-022 Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111; loads drive the same be.
REQ-023 Store data replicated: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-024 Load data: lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged; stores return rdata=0.
REQ-025 Timeout counter clears on accept, increments each REQ/WAIT cycle; on reaching WAIT_MAX (nonzero) -> RESP, err=1, rdata=0, bus_req_o dropped.
REQ-026 rsp_rd_o echoes captured req_rd_i for every response, including errors.

Reset
REQ-027 rst high: state IDLE, counter 0, all outputs 0 except req_ready_o=1 (asynchronous assertion).
REQ-028 rst mid-transaction abandons the access, bus_req_o drops immediately, no response is produced.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=00 is illegal per REQ-016/017 (err=1, no bus access).
REQ-030 Macro undefined: misaligned access proceeds with offending low address bits cleared (H: addr[0]=0; W: addr[1:0]=00), err=0.

Verification
REQ-031 LB addr 0x103, rdata 0x80xxxxxx, gnt immediate, rvalid next -> be 4'b1000, bus_addr 0x100, rsp_rdata 0xFFFFFF80 at N+3, err 0.
REQ-032 SH addr 0x206, wdata 0x0000BEEF -> bus_wdata 0xBEEFBEEF, be 4'b1100, we 1, rsp_rdata 0, err 0.
REQ-033 LW, gnt withheld 3 cycles -> bus_req_o and addr stable 4 cycles, response after rvalid, busy_o high throughout.
REQ-034 WAIT_MAX=8, LW with rvalid never asserted -> rsp_valid with err=1, rdata 0 after 8 bus cycles; later stray rvalid ignored.
REQ-035 LW addr 0x302: with LSU_MISALIGN_TRAP_EN -> no bus_req, err=1 at N+1; without -> bus_addr 0x300, be 4'b1111, err 0.
REQ-036 rst asserted in WAIT -> bus_req_o/rsp_valid_o 0 immediately, req_ready_o 1; next LBU completes normally.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: sequences one RV32 load/store at a time onto a simple req/gnt + rvalid bus.
// Latency: accept N, bus_req_o N+1, rsp_valid_o N+3 with immediate gnt and rvalid; illegal access responds at N+1.
// Backpressure: req_ready_o only in IDLE; bus_req_o and its fields are held until bus_gnt_i; optional WAIT_MAX timeout.
//
// Ports:
//   clk, rst                - single clock, asynchronous active-high reset
//   req_*                   - request from execute (valid/ready, we, funct3, addr, wdata, rd)
//   bus_req_o/bus_gnt_i     - address phase; bus_addr_o/bus_we_o/bus_be_o/bus_wdata_o valid with bus_req_o
//   bus_rvalid_i/bus_rdata_i- response phase (store ack or load data)
//   rsp_*                   - one-cycle writeback response (rd, rdata, err)
//   busy_o                  - high whenever not IDLE
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors
// instead of silently clearing the offending address bits.
module lsu_bus_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rsp_valid_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    // Counter must hold WAIT_MAX itself (reached when gnt arrives on the last REQ cycle).
    localparam int unsigned CW      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam bit          TO_EN   = (WAIT_MAX != 0);
    localparam int unsigned LIM_INT = TO_EN ? (WAIT_MAX - 1) : 0;
    localparam logic [CW-1:0] CNT_LIM = CW'(LIM_INT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [4:0]    rd_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          illegal_in;
    logic          misalign_in;
    logic          bad_in;
    logic [31:0]   addr_in;
    logic [3:0]    be_in;
    logic [31:0]   wdata_in;
    logic          timeout;

    assign accept  = req_valid_i && (state == S_IDLE);
    // Fires on the WAIT_MAX-th REQ/WAIT cycle; >= covers a gnt that lands on the limit cycle.
    assign timeout = TO_EN && (cnt_q >= CNT_LIM);

    // Request decode: legality, address cleanup, byte enables and lane-replicated store data.
    always_comb begin
        illegal_in  = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                      (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
        misalign_in = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                      ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        addr_in     = req_addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
        bad_in      = illegal_in || misalign_in;
`else
        bad_in      = illegal_in;
        // Misaligned accesses proceed at the naturally aligned address below them.
        if (req_funct3_i[1:0] == 2'b01) begin
            addr_in[0] = 1'b0;
        end else if (req_funct3_i[1:0] == 2'b10) begin
            addr_in[1:0] = 2'b00;
        end
`endif
        case (req_funct3_i[1:0])
            2'b00: begin
                be_in    = 4'b0001 << addr_in[1:0];
                wdata_in = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << {addr_in[1], 1'b0};
                wdata_in = {2{req_wdata_i[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = req_wdata_i;
            end
        endcase
    end

    // Lane select plus sign/zero extension of load data.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        bus_req_o   = 1'b0;
        bus_addr_o  = 32'h0;
        bus_we_o    = 1'b0;
        bus_be_o    = 4'h0;
        bus_wdata_o = 32'h0;
        rsp_valid_o = 1'b0;
        rsp_rd_o    = 5'h0;
        rsp_rdata_o = 32'h0;
        rsp_err_o   = 1'b0;
        busy_o      = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (accept) begin
                    state_nxt = bad_in ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                bus_req_o   = 1'b1;
                bus_addr_o  = {addr_q[31:2], 2'b00};
                bus_we_o    = we_q;
                bus_be_o    = be_q;
                bus_wdata_o = wdata_q;
                if (bus_gnt_i) begin
                    state_nxt = S_WAIT;
                end else if (timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i || timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_rd_o    = rd_q;
                rsp_rdata_o = rdata_q;
                rsp_err_o   = err_q;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            rd_q     <= 5'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q     <= req_we_i;
                        funct3_q <= req_funct3_i;
                        addr_q   <= addr_in;
                        be_q     <= be_in;
                        wdata_q  <= wdata_in;
                        rd_q     <= req_rd_i;
                        rdata_q  <= 32'h0;
                        err_q    <= bad_in;
                        cnt_q    <= '0;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!bus_gnt_i && timeout) begin
                        err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_rvalid_i) begin
                        rdata_q <= we_q ? 32'h0 : load_extract(funct3_q, addr_q[1:0], bus_rdata_i);
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Testbench for lsu_bus_ctrl (WAIT_MAX=8): directed loads/stores with a scoreboard.
// Stimulus pushes expected bus address phases and responses; a negedge monitor pops and compares.
// Follows the LSU_MISALIGN_TRAP_EN build option for misaligned-access expectations.
module tb_lsu_bus_ctrl;

    localparam int WMAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'h0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    lsu_bus_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_rd_i     (req_rd),
        .bus_req_o    (bus_req),
        .bus_gnt_i    (bus_gnt),
        .bus_addr_o   (bus_addr),
        .bus_we_o     (bus_we),
        .bus_be_o     (bus_be),
        .bus_wdata_o  (bus_wdata),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rd_o     (rsp_rd),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented bus address phase and response against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("bus_addr", bus_addr, bus_q[0].addr);
                    chk("bus_we", {31'h0, bus_we}, {31'h0, bus_q[0].we});
                    chk("bus_be", {28'h0, bus_be}, {28'h0, bus_q[0].be});
                    chk("bus_wdata", bus_wdata, bus_q[0].wdata);
                    chk("busy_in_req", {31'h0, busy}, 32'd1);
                    if (bus_gnt) void'(bus_q.pop_front());
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rsp_exp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_rd", {27'h0, rsp_rd}, {27'h0, e.rd});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("busy_in_resp", {31'h0, busy}, 32'd1);
                end
            end
        end
    end

    // Issue one request and play the bus side. rdly < 0 means rvalid never comes.
    // e_lat is the expected accept-to-response distance in cycles.
    task automatic issue(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [4:0]  rd,
        input int          gdly,
        input int          rdly,
        input logic [31:0] rdata,
        input logic        exp_bus,
        input logic [31:0] e_addr,
        input logic [3:0]  e_be,
        input logic [31:0] e_wdata,
        input logic [31:0] e_rdata,
        input logic        e_err,
        input int          e_lat,
        input logic        rst_in_wait
    );
        int t;
        int acc;
        bus_exp_t be;
        rsp_exp_t re;
        t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        chk("req_ready_wait", {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        acc = cyc;
        if (exp_bus) begin
            be.addr = e_addr; be.we = we; be.be = e_be; be.wdata = e_wdata;
            bus_q.push_back(be);
        end
        if (!rst_in_wait) begin
            re.rd = rd; re.rdata = e_rdata; re.err = e_err; re.cyc = acc + e_lat;
            rsp_q.push_back(re);
        end
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_0000;
        req_wdata = 32'h5555_5555;
        req_rd    = 5'h1F;
        if (exp_bus) begin
            chk("bus_req_at_n1", {31'h0, bus_req}, 32'd1);
            repeat (gdly) tick();
            bus_gnt = 1'b1;
            tick();
            bus_gnt = 1'b0;
            if (rst_in_wait) begin
                rst = 1'b1;
                #1;
                chk("rst_bus_req", {31'h0, bus_req}, 32'd0);
                chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
                chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
                chk("rst_busy", {31'h0, busy}, 32'd0);
                tick();
                rst = 1'b0;
            end else if (rdly >= 0) begin
                repeat (rdly) tick();
                bus_rvalid = 1'b1;
                bus_rdata  = rdata;
                tick();
                bus_rvalid = 1'b0;
                bus_rdata  = 32'h0;
            end
        end
    endtask

    initial begin
        int t;
        // Reset state
        repeat (2) tick();
        chk("reset_req_ready", {31'h0, req_ready}, 32'd1);
        chk("reset_bus_req", {31'h0, bus_req}, 32'd0);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'h0, busy}, 32'd0);
        chk("reset_bus_addr", bus_addr, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // LB 0x103, sign-extended top byte
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 0, 0, 32'h8012_3456,
              1'b1, 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b0);
        // SH 0x206, replicated halfword, rdata ignored for stores
        issue(1'b1, 3'b001, 32'h0000_0206, 32'h0000_BEEF, 5'd6, 0, 0, 32'hDEAD_BEEF,
              1'b1, 32'h0000_0204, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 3, 1'b0);
        // LW with gnt withheld 3 cycles
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd7, 3, 0, 32'h1234_5678,
              1'b1, 32'h0000_0400, 4'b1111, 32'h0, 32'h1234_5678, 1'b0, 6, 1'b0);
        // LHU upper half, rvalid delayed 2
        issue(1'b0, 3'b101, 32'h0000_010A, 32'h0, 5'd8, 0, 2, 32'hABCD_1234,
              1'b1, 32'h0000_0108, 4'b1100, 32'h0, 32'h0000_ABCD, 1'b0, 5, 1'b0);
        // LH lower half, negative
        issue(1'b0, 3'b001, 32'h0000_0108, 32'h0, 5'd9, 0, 0, 32'h0000_F00F,
              1'b1, 32'h0000_0108, 4'b0011, 32'h0, 32'hFFFF_F00F, 1'b0, 3, 1'b0);
        // LBU byte 1
        issue(1'b0, 3'b100, 32'h0000_0101, 32'h0, 5'd10, 0, 0, 32'h0000_A500,
              1'b1, 32'h0000_0100, 4'b0010, 32'h0, 32'h0000_00A5, 1'b0, 3, 1'b0);
        // SB byte 3
        issue(1'b1, 3'b000, 32'h0000_00FF, 32'h1234_56C3, 5'd11, 1, 1, 32'h0,
              1'b1, 32'h0000_00FC, 4'b1000, 32'hC3C3_C3C3, 32'h0, 1'b0, 5, 1'b0);
        // SW
        issue(1'b1, 3'b010, 32'h0000_0500, 32'hCAFE_F00D, 5'd12, 0, 0, 32'h0,
              1'b1, 32'h0000_0500, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 1'b0);
        // Illegal encodings: no bus activity, error at N+1
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd13, 0, 0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b1, 3'b100, 32'h0000_0010, 32'h0000_00FF, 5'd14, 0, 0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b0, 3'b110, 32'h0000_0020, 32'h0, 5'd15, 0, 0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h0000_0302, 32'h0, 5'd16, 0, 0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0203, 32'h0, 5'd17, 0, 0, 32'h0,
              1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 1'b0);
`else
        issue(1'b0, 3'b010, 32'h0000_0302, 32'h0, 5'd16, 0, 0, 32'h1122_3344,
              1'b1, 32'h0000_0300, 4'b1111, 32'h0, 32'h1122_3344, 1'b0, 3, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0203, 32'h0, 5'd17, 0, 0, 32'h8001_FFFF,
              1'b1, 32'h0000_0200, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 3, 1'b0);
`endif
        // Timeout: rvalid never comes, error after WMAX bus cycles
        issue(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd18, 0, -1, 32'h0,
              1'b1, 32'h0000_0600, 4'b1111, 32'h0, 32'h0, 1'b1, WMAX + 1, 1'b0);
        // Stray rvalid once idle must not produce a response
        t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        chk("idle_after_timeout", {31'h0, req_ready}, 32'd1);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h7777_7777;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        repeat (3) tick();
        // Reset while in WAIT abandons the access
        issue(1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd19, 0, 0, 32'h0,
              1'b1, 32'h0000_0700, 4'b1111, 32'h0, 32'h0, 1'b0, 0, 1'b1);
        repeat (2) tick();
        // LBU after reset completes normally
        issue(1'b0, 3'b100, 32'h0000_0702, 32'h0, 5'd20, 0, 0, 32'h00FF_0000,
              1'b1, 32'h0000_0700, 4'b0100, 32'h0, 32'h0000_00FF, 1'b0, 3, 1'b0);

        repeat (6) tick();
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
